i2s_tx: RTL and testbench

Serializes the processed 32-bit audio sample stream (the `audio_out_valid`/`audio_out_data` strobe stream produced by the effect chain) onto a standard Philips I2S link toward the DAC. It is the transmit end of the same valid-strobe sample interface the effects consume and produce. It generates BCLK and LRCK as bus master, buffers up to two samples, and sends each mono sample on both left and right slots. Underrun and overflow are flagged rather than stalled, because the stream has no backpressure.

---
 rtl/audio_pkg.sv | 9 +
 rtl/i2s_tx_if.sv | 26 ++
 rtl/sample_fifo2.sv | 52 +++++
 rtl/i2s_tx.sv | 119 +++++++++++
 tb/tb_i2s_tx.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: constants shared by the audio sample path.
//   SAMPLE_W   - width of one mono sample on the valid-strobe stream
//   SLOT_BITS  - BCLK periods per I2S slot (left or right)
//   FRAME_BITS - BCLK periods per I2S frame (left + right)
package audio_pkg;
  localparam int SAMPLE_W   = 32;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
endpackage

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: groups the sample stream input, the pacing/status flags and
// the three I2S pins.
//   master - upstream side: drives sample_valid/sample_data, observes the rest
//   slave  - transmitter side (i2s_tx)
interface i2s_tx_if;
  import audio_pkg::*;

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_req;
  logic                underrun;
  logic                overflow;
  logic                i2s_bclk;
  logic                i2s_lrck;
  logic                i2s_sdata;

  modport master (
    output sample_valid, sample_data,
    input  sample_req, underrun, overflow, i2s_bclk, i2s_lrck, i2s_sdata
  );

  modport slave (
    input  sample_valid, sample_data,
    output sample_req, underrun, overflow, i2s_bclk, i2s_lrck, i2s_sdata
  );
endinterface

// File: rtl/sample_fifo2.sv
// sample_fifo2: 2-entry synchronous FIFO for audio samples.
//   i_push/i_data - write request and data
//   i_pop         - read request; o_data is the current head
//   o_full/o_empty - occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module sample_fifo2
  import audio_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [SAMPLE_W-1:0] i_data,
  output logic                o_full,
  output logic                o_empty,
  output logic [SAMPLE_W-1:0] o_data
);
  logic [SAMPLE_W-1:0] r_mem [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;
  logic                w_do_pop;
  logic                w_do_push;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_data  = r_mem[r_rd_ptr];

  // Storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S transmitter (bus master) for a mono sample stream.
//   clk, rst - system clock, synchronous active-high reset
//   bus      - i2s_tx_if.slave: sample_valid/sample_data in; sample_req,
//              underrun, overflow flags and i2s_bclk/i2s_lrck/i2s_sdata out
// Each sample is sent MSB first on both the left and right slot. LRCK
// changes one BCLK ahead of the slot's MSB. All link state moves on BCLK
// falling edges, in the clk cycle the registered BCLK goes low.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = 4
)
(
  input  logic     clk,
  input  logic     rst,
  i2s_tx_if.slave  bus
);
  localparam int DIV_W = $clog2(BCLK_DIV);

  logic [DIV_W-1:0]    r_div_cnt;
  logic                r_bclk;
  logic                r_lrck;
  logic                r_sdata;
  logic                r_req;
  logic                r_und;
  logic                r_ovf;
  logic [5:0]          r_bit_cnt;
  logic [SAMPLE_W-1:0] r_hold;
  logic [SAMPLE_W-1:0] r_shreg;

  logic                w_tc;
  logic                w_fall;
  logic                w_frame;
  logic                w_slot;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [SAMPLE_W-1:0] w_head;
  logic [5:0]          w_bit_nxt;

  assign w_tc      = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
  assign w_fall    = w_tc && r_bclk;
  assign w_frame   = w_fall && (r_bit_cnt == 6'(FRAME_BITS - 1));
  assign w_slot    = w_fall && (r_bit_cnt == 6'(SLOT_BITS - 1));
  assign w_pop     = w_frame && !w_empty;
  assign w_bit_nxt = r_bit_cnt + 6'd1;

  sample_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.sample_valid),
    .i_pop   (w_pop),
    .i_data  (bus.sample_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_data  (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_lrck    <= 1'b0;
      r_sdata   <= 1'b0;
      r_req     <= 1'b0;
      r_und     <= 1'b0;
      r_ovf     <= 1'b0;
      r_bit_cnt <= 6'd63;
      r_hold    <= '0;
      r_shreg   <= '0;
    end else begin
      r_req <= 1'b0;
      r_und <= 1'b0;

      // A pop in the same cycle frees a slot, so only a true full drops.
      if (bus.sample_valid && w_full && !w_pop) r_ovf <= 1'b1;

      if (w_tc) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end

      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        // Word select leads the slot MSB by one bit period.
        r_lrck    <= (w_bit_nxt >= 6'(SLOT_BITS - 1)) &&
                     (w_bit_nxt <= 6'(FRAME_BITS - 2));
        if (w_frame) begin
          if (w_pop) begin
            r_hold  <= w_head;
            r_shreg <= w_head;
            r_sdata <= w_head[SAMPLE_W-1];
            r_req   <= 1'b1;
          end else begin
            // Empty FIFO: repeat the last sample rather than stall.
            r_shreg <= r_hold;
            r_sdata <= r_hold[SAMPLE_W-1];
            r_und   <= 1'b1;
          end
        end else if (w_slot) begin
          r_shreg <= r_hold;
          r_sdata <= r_hold[SAMPLE_W-1];
        end else begin
          r_shreg <= {r_shreg[SAMPLE_W-2:0], 1'b0};
          r_sdata <= r_shreg[SAMPLE_W-2];
        end
      end
    end
  end

  assign bus.i2s_bclk   = r_bclk;
  assign bus.i2s_lrck   = r_lrck;
  assign bus.i2s_sdata  = r_sdata;
  assign bus.sample_req = r_req;
  assign bus.underrun   = r_und;
  assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;
  localparam int D = 2;
  localparam logic [63:0] LR_PAT = 64'h7FFF_FFFF_8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2s_tx_if bus();

  i2s_tx #(.BCLK_DIV(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // spec model state, advanced on each posedge from bench-driven inputs
  int          m_e = 0;
  int          m_bit = 63;
  bit          m_fall = 0;
  bit          m_bclk = 0;
  bit          m_req = 0;
  bit          m_und = 0;
  bit          m_ovf = 0;
  logic [31:0] m_hold = '0;
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];

  // monitor state
  bit          mon_en = 0;
  int          n_req = 0, n_und = 0;
  int          n_req_exp = 0, n_und_exp = 0;
  int          bclk_err = 0, pulse_err = 0, ovf_err = 0;
  int          frames_done = 0;
  logic [31:0] dec_l = '0, dec_r = '0, last_left = '0;
  logic [63:0] dec_lr = '0;
  bit          st_en = 0, st_valid = 0;
  logic        st_lvl = 1'b0;
  int          st_len = 0;
  int          hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_e = 0; m_bit = 63; m_fall = 0; m_bclk = 0;
      m_req = 0; m_und = 0; m_ovf = 0; m_hold = '0;
      mq.delete();
      exp_q.delete();
    end else begin
      m_e++;
      m_req = 0;
      m_und = 0;
      m_fall = ((m_e % (2 * D)) == 0);
      if ((m_e % D) == 0) m_bclk = ~m_bclk;
      if (m_fall) begin
        m_bit = (m_bit + 1) % 64;
        if (m_bit == 0) begin
          if (mq.size() > 0) begin
            m_hold = mq.pop_front();
            m_req = 1;
            n_req_exp++;
          end else begin
            m_und = 1;
            n_und_exp++;
          end
          exp_q.push_back(m_hold);
        end
      end
      if (bus.sample_valid === 1'b1) begin
        if (mq.size() < 2) mq.push_back(bus.sample_data);
        else m_ovf = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (bus.i2s_bclk !== m_bclk) bclk_err++;
      if (bus.sample_req !== m_req || bus.underrun !== m_und) pulse_err++;
      if (bus.overflow !== m_ovf) ovf_err++;
      if (bus.sample_req === 1'b1) n_req++;
      if (bus.underrun === 1'b1) n_und++;
      if (st_en) begin
        if (bus.i2s_bclk !== st_lvl) begin
          if (st_valid) begin
            if (st_lvl === 1'b1) begin
              if (st_len < hi_min) hi_min = st_len;
              if (st_len > hi_max) hi_max = st_len;
            end else begin
              if (st_len < lo_min) lo_min = st_len;
              if (st_len > lo_max) lo_max = st_len;
            end
          end
          st_valid = 1;
          st_len = 1;
          st_lvl = bus.i2s_bclk;
        end else begin
          st_len++;
        end
      end
      if (m_fall) begin
        if (m_bit < 32) dec_l[31 - m_bit] = bus.i2s_sdata;
        else            dec_r[63 - m_bit] = bus.i2s_sdata;
        dec_lr[m_bit] = bus.i2s_lrck;
        if (m_bit == 63) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL frame_scoreboard got=frame exp=no_frame_expected");
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (dec_l !== e) begin
              failures++;
              $display("FAIL frame_left got=%h exp=%h", dec_l, e);
            end
            checks++;
            if (dec_r !== e) begin
              failures++;
              $display("FAIL frame_right got=%h exp=%h", dec_r, e);
            end
          end
          checks++;
          if (dec_lr !== LR_PAT) begin
            failures++;
            $display("FAIL frame_lrck got=%h exp=%h", dec_lr, LR_PAT);
          end
          last_left = dec_l;
          frames_done++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [31:0] d);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_data = d;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int target = frames_done + n;
    int cnt = 0;
    while (frames_done < target && cnt < n * 300 + 600) begin
      @(negedge clk);
      cnt++;
    end
    if (frames_done < target) begin
      checks++;
      failures++;
      $display("FAIL wait_frames got=%0d exp=%0d", frames_done, target);
    end
  endtask

  task automatic wait_bit(input int b);
    int cnt = 0;
    @(negedge clk);
    while (!(m_fall && m_bit == b) && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 2000) begin
      checks++;
      failures++;
      $display("FAIL wait_bit got=timeout exp=bit%0d", b);
    end
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = {bus.i2s_bclk, bus.i2s_lrck, bus.i2s_sdata,
           bus.sample_req, bus.underrun, bus.overflow};
    checks++;
    if (obs !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000", obs);
    end
    mon_en = 1;
    rst = 1'b0;
  endtask

  task automatic test_first_sample();
    int r0 = n_req, u0 = n_und;
    push(32'h8000_0001);
    wait_frames(1);
    checks++;
    if (last_left !== 32'h8000_0001) begin
      failures++;
      $display("FAIL first_sample got=%h exp=80000001", last_left);
    end
    checks++;
    if (n_req - r0 !== 1 || n_und - u0 !== 0) begin
      failures++;
      $display("FAIL first_flags got=req%0d_und%0d exp=req1_und0", n_req - r0, n_und - u0);
    end
  endtask

  task automatic test_underrun();
    int u0, r0;
    do_reset();
    u0 = n_und;
    r0 = n_req;
    wait_frames(3);
    checks++;
    if (n_und - u0 !== 3 || n_req - r0 !== 0) begin
      failures++;
      $display("FAIL underrun_count got=und%0d_req%0d exp=und3_req0", n_und - u0, n_req - r0);
    end
    checks++;
    if (last_left !== 32'h0) begin
      failures++;
      $display("FAIL underrun_zero got=%h exp=00000000", last_left);
    end
    push(32'h1234_5678);
    wait_frames(1);
    checks++;
    if (last_left !== 32'h1234_5678) begin
      failures++;
      $display("FAIL after_underrun got=%h exp=12345678", last_left);
    end
  endtask

  task automatic test_overflow();
    int u0, r0;
    wait_bit(10);
    u0 = n_und;
    r0 = n_req;
    push(32'hA1A1_0001);
    push(32'hB2B2_0002);
    push(32'hC3C3_0003);
    checks++;
    if (bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set got=%b exp=1", bus.overflow);
    end
    wait_frames(4);
    checks++;
    if (last_left !== 32'hB2B2_0002) begin
      failures++;
      $display("FAIL overflow_repeat got=%h exp=b2b20002", last_left);
    end
    checks++;
    if (n_und - u0 !== 1 || n_req - r0 !== 2) begin
      failures++;
      $display("FAIL overflow_flags got=und%0d_req%0d exp=und1_req2", n_und - u0, n_req - r0);
    end
  endtask

  task automatic test_full_boundary_push();
    int cnt = 0;
    do_reset();
    wait_bit(10);
    push(32'h1111_AAAA);
    push(32'h2222_BBBB);
    while (!(m_bit == 63 && ((m_e + 1) % (2 * D)) == 0) && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    bus.sample_valid = 1'b1;
    bus.sample_data = 32'h3333_CCCC;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL boundary_no_overflow got=%b exp=0", bus.overflow);
    end
    wait_frames(3);
    checks++;
    if (last_left !== 32'h3333_CCCC) begin
      failures++;
      $display("FAIL boundary_new_sample got=%h exp=3333cccc", last_left);
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] obs;
    logic prev;
    int fk = 0;
    wait_bit(5);
    push(32'h0000_0001);
    push(32'h0000_0002);
    push(32'h0000_0003);
    checks++;
    if (bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_overflow got=%b exp=1", bus.overflow);
    end
    wait_bit(40);
    rst = 1'b1;
    @(negedge clk);
    obs = {bus.i2s_bclk, bus.i2s_lrck, bus.i2s_sdata,
           bus.sample_req, bus.underrun, bus.overflow};
    checks++;
    if (obs !== 6'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%b exp=000000", obs);
    end
    rst = 1'b0;
    prev = bus.i2s_bclk;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (fk == 0 && prev === 1'b1 && bus.i2s_bclk === 1'b0) fk = k;
      prev = bus.i2s_bclk;
    end
    checks++;
    if (fk !== 2 * D) begin
      failures++;
      $display("FAIL first_fall got=%0d exp=%0d", fk, 2 * D);
    end
  endtask

  task automatic test_steady_stream();
    int u0, r0;
    st_valid = 0;
    st_lvl = bus.i2s_bclk;
    st_en = 1;
    wait_bit(32);
    u0 = n_und;
    r0 = n_req;
    for (int i = 0; i < 100; i++) begin
      push($urandom);
      repeat (255) @(negedge clk);
    end
    st_en = 0;
    checks++;
    if (n_und - u0 !== 0 || n_req - r0 !== 100) begin
      failures++;
      $display("FAIL stream_flags got=und%0d_req%0d exp=und0_req100", n_und - u0, n_req - r0);
    end
    checks++;
    if (bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL stream_overflow got=%b exp=0", bus.overflow);
    end
    checks++;
    if (hi_min !== D || hi_max !== D || lo_min !== D || lo_max !== D) begin
      failures++;
      $display("FAIL bclk_duty got=hi%0d..%0d_lo%0d..%0d exp=%0d", hi_min, hi_max, lo_min, lo_max, D);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (bclk_err !== 0) begin
      failures++;
      $display("FAIL bclk_timing got=%0d exp=0", bclk_err);
    end
    checks++;
    if (pulse_err !== 0) begin
      failures++;
      $display("FAIL pulse_timing got=%0d exp=0", pulse_err);
    end
    checks++;
    if (ovf_err !== 0) begin
      failures++;
      $display("FAIL overflow_timing got=%0d exp=0", ovf_err);
    end
    checks++;
    if (n_req !== n_req_exp || n_und !== n_und_exp) begin
      failures++;
      $display("FAIL pulse_totals got=req%0d_und%0d exp=req%0d_und%0d", n_req, n_und, n_req_exp, n_und_exp);
    end
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_underrun();
    test_overflow();
    test_full_boundary_push();
    test_mid_reset();
    test_steady_stream();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
